// File: rtl/static_control_bank.sv
// static_control_bank: shadowed control words applied immediately or on sync_pulse; STATIC_CTRL_READBACK_EN adds a readback port
module static_control_bank #(
    parameter int CHANNELS = 8,
    parameter int WIDTH = 16,
    parameter int ADDR_W = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int ARM_TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_stb,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit_stb,
    input  logic                      sync_mode,
    input  logic                      sync_pulse,
    input  logic                      cancel_stb,
`ifdef STATIC_CTRL_READBACK_EN
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic                      rd_sel,
    output logic [WIDTH-1:0]          rd_data,
`endif
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      pending,
    output logic                      applied,
    output logic                      err
);
    localparam int CW = ARM_TIMEOUT > 1 ? $clog2(ARM_TIMEOUT) : 1;
    typedef enum logic {IDLE, ARMED} state_t;
    state_t state_q, state_d;
    logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d, dout_q, dout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic applied_q, applied_d, err_q, err_d;
    logic wr_ok, apply, expire;
    always_comb begin
        wr_ok = wr_stb && (32'(wr_addr) < CHANNELS);
        shadow_d = shadow_q;
        for (int i = 0; i < CHANNELS; i++)
            if (wr_ok && 32'(wr_addr) == i) shadow_d[i] = wr_data;
        expire = ARM_TIMEOUT != 0 && 32'(cnt_q) == ARM_TIMEOUT - 1;
        apply = state_q == IDLE ? commit_stb && !sync_mode : sync_pulse && !cancel_stb;
        state_d = state_q == IDLE ? (commit_stb && sync_mode ? ARMED : IDLE)
                : (cancel_stb || sync_pulse || expire ? IDLE : ARMED);
        cnt_d = state_q == ARMED && state_d == ARMED ? cnt_q + CW'(1) : '0;
        // shadow_d rather than shadow_q so a same-cycle write lands in the applied value
        dout_d = apply ? shadow_d : dout_q;
        applied_d = apply;
        err_d = (wr_stb && !wr_ok) || (state_q == ARMED && !cancel_stb && !sync_pulse && expire);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= {CHANNELS{RESET_VALUE}};
            dout_q    <= {CHANNELS{RESET_VALUE}};
            state_q   <= IDLE;
            cnt_q     <= '0;
            applied_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            dout_q    <= dout_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            applied_q <= applied_d;
            err_q     <= err_d;
        end
    end
    assign dout    = dout_q;
    assign pending = state_q == ARMED;
    assign applied = applied_q;
    assign err     = err_q;
`ifdef STATIC_CTRL_READBACK_EN
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (32'(rd_addr) == i) rd_data_d = rd_sel ? dout_q[i] : shadow_q[i];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else rd_data_q <= rd_data_d;
    end
    assign rd_data = rd_data_q;
`endif
endmodule

// File: doc/static_control_bank.md
STATIC_CONTROL_BANK -- requirements
Module: static_control_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 8, giving the number of independent static control words.
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the bits per control word.
REQ-003 The block SHALL have parameter ADDR_W, default 3, giving the width of wr_addr.
REQ-004 The block SHALL have parameter RESET_VALUE, default 0, a WIDTH-bit value applied to every shadow and active word on reset.
REQ-005 The block SHALL have parameter ARM_TIMEOUT, default 0, giving the maximum cycles spent in ARMED; 0 means no timeout.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port wr_stb, input, 1 bit: single-cycle shadow write strobe.
REQ-009 The block SHALL have port wr_addr, input, ADDR_W bits: shadow channel index.
REQ-010 The block SHALL have port wr_data, input, WIDTH bits: shadow write data.
REQ-011 The block SHALL have port commit_stb, input, 1 bit: request to copy all shadows to active outputs.
REQ-012 The block SHALL have port sync_mode, input, 1 bit: 0 = apply immediately, 1 = apply on next sync_pulse.
REQ-013 The block SHALL have port sync_pulse, input, 1 bit: external apply point, e.g. frame start.
REQ-014 The block SHALL have port cancel_stb, input, 1 bit: abandon an armed commit.
REQ-015 The block SHALL have port dout, output, CHANNELS*WIDTH bits: active words, channel n at bits [n*WIDTH +: WIDTH].
REQ-016 The block SHALL have port pending, output, 1 bit: high while in ARMED.
REQ-017 The block SHALL have port applied, output, 1 bit: one-cycle pulse in the cycle after dout updates.
REQ-018 The block SHALL have port err, output, 1 bit: one-cycle pulse on an out-of-range write or an arm timeout.

Function
REQ-019 On wr_stb with wr_addr < CHANNELS, shadow[wr_addr] SHALL take wr_data at that edge.
REQ-020 On wr_stb with wr_addr >= CHANNELS, no shadow SHALL change and err SHALL pulse the next cycle.
REQ-021 The FSM SHALL have states IDLE and ARMED.
REQ-022 In IDLE with commit_stb and sync_mode=0, dout SHALL load all shadows at that edge (latency 1), state SHALL remain IDLE, and applied SHALL pulse the following cycle.
REQ-023 In IDLE with commit_stb and sync_mode=1, the FSM SHALL go to ARMED and dout SHALL stay unchanged; a sync_pulse in that same cycle SHALL NOT count.
REQ-024 In ARMED, the first sync_pulse SHALL load dout from the shadows, pulse applied the following cycle, and return to IDLE.
REQ-025 In ARMED, commit_stb SHALL be ignored and sync_mode changes SHALL have no effect.
REQ-026 In ARMED, cancel_stb SHALL return the FSM to IDLE without updating dout; cancel_stb SHALL win over a simultaneous sync_pulse.
REQ-027 cancel_stb in IDLE SHALL have no effect.
REQ-028 A wr_stb in the same cycle as an apply (immediate commit or sync_pulse) SHALL be included in the applied value, i.e. the write data bypasses to dout.
REQ-029 Writes during ARMED SHALL update shadows, and the apply SHALL use the shadow contents at the apply edge.
REQ-030 With ARM_TIMEOUT=T>0, a T-cycle counter SHALL start on entry to ARMED; after T cycles in ARMED without sync_pulse or cancel_stb, the FSM SHALL return to IDLE, pulse err, and leave dout unchanged.
REQ-031 A sync_pulse in the same cycle the timeout expires SHALL win, and no err pulse SHALL occur.
REQ-032 Shadow writes SHALL never change dout except through an apply.

Reset
REQ-033 On rst, all shadow and active words SHALL reset to RESET_VALUE, the state to IDLE, the timeout counter to 0, and pending, applied, err to 0.
REQ-034 An rst asserted during ARMED SHALL discard the armed commit, and no applied pulse SHALL follow.
REQ-035 Reset SHALL act asynchronously on assertion; the first commit SHALL be accepted on the first clk edge after deassertion.

Configuration
REQ-036 When macro STATIC_CTRL_READBACK_EN is defined, the block SHALL add ports rd_addr (input, ADDR_W bits), rd_sel (input, 1 bit: 0 = shadow, 1 = active), and rd_data (output, WIDTH bits), with rd_data registered at latency 1 and reading 0 for out-of-range rd_addr.
REQ-037 When STATIC_CTRL_READBACK_EN is undefined, the readback ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 The bench SHALL cover: reset, then write ch2=0x1234, commit_stb with sync_mode=0 -> dout ch2=0x1234 one edge later, applied pulses once, other channels at RESET_VALUE.
REQ-039 The bench SHALL cover: sync_mode=1 commit, write ch0=0xBEEF while ARMED, sync_pulse 5 cycles later -> pending high for 5 cycles, then dout ch0=0xBEEF and pending=0.
REQ-040 The bench SHALL cover: ARMED, then cancel_stb and sync_pulse in the same cycle -> dout unchanged, IDLE, no applied pulse.
REQ-041 The bench SHALL cover: ARM_TIMEOUT=4, arm with no sync_pulse -> err pulse after 4 cycles, IDLE, dout unchanged.
REQ-042 The bench SHALL cover: wr_addr=CHANNELS -> err pulse, no shadow changed; a wr_stb to ch1=0x00FF in the same cycle as an immediate commit -> dout ch1=0x00FF.
REQ-043 The bench SHALL cover: rst asserted mid-ARMED -> all outputs return to reset values immediately, and a later sync_pulse does not update dout.
